// File: rtl/spi_minion_stream.sv
// ============================================================================
// Module   : spi_minion_stream
// Brief    : SPI minion bridging serial pins to val/rdy request/response streams.
//            Optional error counters enabled by SPI_MINION_STREAM_ERR_CNT_EN.
// Revision : 1.0
// ============================================================================
`default_nettype none

module spi_minion_stream #(
  parameter int NBITS       = 32,
  parameter int CPOL        = 0,
  parameter int CPHA        = 0,
  parameter int SYNC_STAGES = 2
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             sclk,
  input  logic             cs,
  input  logic             mosi,
  output logic             miso,
  input  logic [NBITS-1:0] recv_msg,
  input  logic             recv_val,
  output logic             recv_rdy,
  output logic [NBITS-1:0] send_msg,
  output logic             send_val,
  input  logic             send_rdy,
  output logic             busy,
  output logic             underflow,
  output logic             overflow,
  output logic             frame_err
`ifdef SPI_MINION_STREAM_ERR_CNT_EN
  ,
  output logic [23:0]      err_cnt
`endif
);

  localparam int             c_cw        = $clog2(NBITS + 1);
  localparam logic [c_cw-1:0] c_nbits    = c_cw'(NBITS);
  localparam logic           c_sclk_idle = (CPOL != 0);
  localparam logic [2:0]     c_warm      = 3'(SYNC_STAGES);

  typedef enum logic [1:0] {
    S_IDLE   = 2'd0,
    S_ACTIVE = 2'd1,
    S_COMMIT = 2'd2
  } state_t;

  state_t r_state, w_state_nxt;

  logic [SYNC_STAGES-1:0] r_sclk_sync, r_cs_sync, r_mosi_sync;
  logic                   r_sclk_prev, r_cs_prev;
  logic [2:0]             r_warm;
  logic                   r_armed;

  logic [NBITS-1:0] r_tx_buf, r_shift_out, r_shift_in, r_send_msg;
  logic             r_tx_full, r_send_val, r_first_lead;
  logic [c_cw-1:0]  r_bit_cnt;
  logic             r_underflow, r_overflow, r_frame_err;

  logic w_sclk_s, w_cs_s, w_mosi_s;
  logic w_lead, w_trail, w_sample, w_shift, w_cs_fall, w_cs_rise;

  assign w_sclk_s  = r_sclk_sync[SYNC_STAGES-1];
  assign w_cs_s    = r_cs_sync[SYNC_STAGES-1];
  assign w_mosi_s  = r_mosi_sync[SYNC_STAGES-1];
  assign w_lead    = (w_sclk_s != c_sclk_idle) && (r_sclk_prev == c_sclk_idle);
  assign w_trail   = (w_sclk_s == c_sclk_idle) && (r_sclk_prev != c_sclk_idle);
  assign w_sample  = (CPHA == 0) ? w_lead : w_trail;
  assign w_shift   = (CPHA == 0) ? w_trail : w_lead;
  // Falling edges only count once cs has been seen high on real (post-reset) data.
  assign w_cs_fall = r_armed && !w_cs_s && r_cs_prev;
  assign w_cs_rise = w_cs_s && !r_cs_prev;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_sclk_sync <= {SYNC_STAGES{c_sclk_idle}};
      r_cs_sync   <= {SYNC_STAGES{1'b1}};
      r_mosi_sync <= '0;
      r_sclk_prev <= c_sclk_idle;
      r_cs_prev   <= 1'b1;
      r_warm      <= 3'd0;
      r_armed     <= 1'b0;
    end else begin
      r_sclk_sync <= {r_sclk_sync[SYNC_STAGES-2:0], sclk};
      r_cs_sync   <= {r_cs_sync[SYNC_STAGES-2:0], cs};
      r_mosi_sync <= {r_mosi_sync[SYNC_STAGES-2:0], mosi};
      r_sclk_prev <= w_sclk_s;
      r_cs_prev   <= w_cs_s;
      if (r_warm != c_warm) r_warm <= r_warm + 3'd1;
      if ((r_warm == c_warm) && w_cs_s) r_armed <= 1'b1;
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) r_state <= S_IDLE;
    else        r_state <= w_state_nxt;
  end

  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      S_IDLE:   if (w_cs_fall) w_state_nxt = S_ACTIVE;
      S_ACTIVE: if (w_cs_rise) w_state_nxt = S_COMMIT;
      S_COMMIT: w_state_nxt = S_IDLE;
      default:  w_state_nxt = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_tx_buf     <= '0;
      r_tx_full    <= 1'b0;
      r_shift_out  <= '0;
      r_shift_in   <= '0;
      r_send_msg   <= '0;
      r_send_val   <= 1'b0;
      r_first_lead <= 1'b0;
      r_bit_cnt    <= '0;
      r_underflow  <= 1'b0;
      r_overflow   <= 1'b0;
      r_frame_err  <= 1'b0;
    end else begin
      r_underflow <= 1'b0;
      r_overflow  <= 1'b0;
      r_frame_err <= 1'b0;
      if (recv_val && !r_tx_full) begin
        r_tx_buf  <= recv_msg;
        r_tx_full <= 1'b1;
      end
      if (r_send_val && send_rdy) r_send_val <= 1'b0;
      case (r_state)
        S_IDLE: begin
          if (w_cs_fall) begin
            if (r_tx_full) begin
              r_shift_out <= r_tx_buf;
              r_tx_full   <= 1'b0;
            end else begin
              r_shift_out <= '0;
              r_underflow <= 1'b1;
            end
            r_bit_cnt    <= '0;
            r_shift_in   <= '0;
            r_first_lead <= 1'b0;
          end
        end
        S_ACTIVE: begin
          if (w_sample && (r_bit_cnt != c_nbits)) begin
            r_shift_in <= {r_shift_in[NBITS-2:0], w_mosi_s};
            r_bit_cnt  <= r_bit_cnt + 1'b1;
          end
          // In CPHA=1 the MSB is already on miso, so the first lead only arms shifting.
          if (w_shift && (r_bit_cnt != c_nbits)) begin
            if ((CPHA != 0) && !r_first_lead) r_first_lead <= 1'b1;
            else                               r_shift_out  <= r_shift_out << 1;
          end
        end
        S_COMMIT: begin
          if (r_bit_cnt == c_nbits) begin
            if (!r_send_val || send_rdy) begin
              r_send_msg <= r_shift_in;
              r_send_val <= 1'b1;
            end else begin
              r_overflow <= 1'b1;
            end
          end else begin
            r_frame_err <= 1'b1;
          end
        end
        default: ;
      endcase
    end
  end

  assign miso      = (r_state == S_ACTIVE) ? r_shift_out[NBITS-1] : 1'b0;
  assign busy      = (r_state == S_ACTIVE);
  assign recv_rdy  = !r_tx_full;
  assign send_msg  = r_send_msg;
  assign send_val  = r_send_val;
  assign underflow = r_underflow;
  assign overflow  = r_overflow;
  assign frame_err = r_frame_err;

`ifdef SPI_MINION_STREAM_ERR_CNT_EN
  logic [7:0] r_uf_cnt, r_ov_cnt, r_fe_cnt;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_uf_cnt <= '0;
      r_ov_cnt <= '0;
      r_fe_cnt <= '0;
    end else begin
      if (r_underflow && (r_uf_cnt != 8'hFF)) r_uf_cnt <= r_uf_cnt + 8'd1;
      if (r_overflow  && (r_ov_cnt != 8'hFF)) r_ov_cnt <= r_ov_cnt + 8'd1;
      if (r_frame_err && (r_fe_cnt != 8'hFF)) r_fe_cnt <= r_fe_cnt + 8'd1;
    end
  end

  assign err_cnt = {r_fe_cnt, r_ov_cnt, r_uf_cnt};
`endif

endmodule

`default_nettype wire

// File: tb/tb_spi_minion_stream.sv
// ============================================================================
// Module   : tb_spi_minion_stream
// Brief    : Randomised bench for spi_minion_stream, one 32-bit mode-0 instance
//            and 8-bit instances in modes 1..3, against a frame-level model.
// Revision : 1.0
// ============================================================================
`default_nettype none

module tb_spi_minion_stream;

  localparam int HALF = 8;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic        reset;
  logic        sclk_v [4];
  logic        cs_v   [4];
  logic        mosi_v [4];
  logic        miso_v [4];
  logic [31:0] rm_v   [4];
  logic        rv_v   [4];
  logic        rr_v   [4];
  logic        sv_v   [4];
  logic        srdy_v [4];
  logic        busy_v [4];
  logic        uf_v   [4];
  logic        ov_v   [4];
  logic        fe_v   [4];
  logic [31:0] sm32;
  logic [7:0]  sm8 [1:3];
`ifdef SPI_MINION_STREAM_ERR_CNT_EN
  logic [23:0] ec_v [4];
`endif

  int nb_of   [4] = '{32, 8, 8, 8};
  int cpol_of [4] = '{0, 0, 1, 1};
  int cpha_of [4] = '{0, 1, 0, 1};

  int uf_cnt [4] = '{default: 0};
  int ov_cnt [4] = '{default: 0};
  int fe_cnt [4] = '{default: 0};

  int n_cmp = 0;
  int n_bad = 0;

  // Device-side model: one-entry RX buffer per instance.
  logic        m_full [4];
  logic [31:0] m_word [4];

  spi_minion_stream #(.NBITS(32), .CPOL(0), .CPHA(0), .SYNC_STAGES(2)) u_dut0 (
    .clk(clk), .reset(reset), .sclk(sclk_v[0]), .cs(cs_v[0]), .mosi(mosi_v[0]),
    .miso(miso_v[0]), .recv_msg(rm_v[0]), .recv_val(rv_v[0]), .recv_rdy(rr_v[0]),
    .send_msg(sm32), .send_val(sv_v[0]), .send_rdy(srdy_v[0]), .busy(busy_v[0]),
    .underflow(uf_v[0]), .overflow(ov_v[0]), .frame_err(fe_v[0])
`ifdef SPI_MINION_STREAM_ERR_CNT_EN
    , .err_cnt(ec_v[0])
`endif
  );

  for (genvar m = 1; m < 4; m++) begin : g_mode
    spi_minion_stream #(.NBITS(8), .CPOL(m / 2), .CPHA(m % 2), .SYNC_STAGES(2)) u_dut (
      .clk(clk), .reset(reset), .sclk(sclk_v[m]), .cs(cs_v[m]), .mosi(mosi_v[m]),
      .miso(miso_v[m]), .recv_msg(rm_v[m][7:0]), .recv_val(rv_v[m]), .recv_rdy(rr_v[m]),
      .send_msg(sm8[m]), .send_val(sv_v[m]), .send_rdy(srdy_v[m]), .busy(busy_v[m]),
      .underflow(uf_v[m]), .overflow(ov_v[m]), .frame_err(fe_v[m])
`ifdef SPI_MINION_STREAM_ERR_CNT_EN
      , .err_cnt(ec_v[m])
`endif
    );
  end

  always @(posedge clk) begin
    for (int i = 0; i < 4; i++) begin
      if (uf_v[i] === 1'b1) uf_cnt[i] <= uf_cnt[i] + 1;
      if (ov_v[i] === 1'b1) ov_cnt[i] <= ov_cnt[i] + 1;
      if (fe_v[i] === 1'b1) fe_cnt[i] <= fe_cnt[i] + 1;
    end
  end

  function automatic logic [31:0] get_sm(input int idx);
    if (idx == 0) return sm32;
    return {24'h0, sm8[idx]};
  endfunction

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  task automatic wclk(input int n);
    repeat (n) @(negedge clk);
  endtask

  // SPI master: drives nsent bits of tx MSB-first, returns what it saw on miso.
  task automatic xfer(input int idx, input logic [31:0] tx, input int nsent,
                      input bit hold_cs, output logic [31:0] rx);
    int   nb;
    logic pol, pha;
    nb  = nb_of[idx];
    pol = (cpol_of[idx] != 0);
    pha = (cpha_of[idx] != 0);
    rx  = 32'h0;
    cs_v[idx] = 1'b0;
    wclk(HALF);
    for (int i = 0; i < nsent; i++) begin
      if (!pha) begin
        mosi_v[idx] = tx[nb-1-i];
        wclk(HALF);
        rx = {rx[30:0], miso_v[idx]};
        sclk_v[idx] = ~pol;
        wclk(HALF);
        sclk_v[idx] = pol;
      end else begin
        sclk_v[idx] = ~pol;
        mosi_v[idx] = tx[nb-1-i];
        wclk(HALF);
        rx = {rx[30:0], miso_v[idx]};
        sclk_v[idx] = pol;
        wclk(HALF);
      end
    end
    wclk(HALF);
    if (!hold_cs) begin
      cs_v[idx] = 1'b1;
      wclk(2 * HALF);
    end
  endtask

  task automatic preload(input int idx, input logic [31:0] w);
    check($sformatf("recv_rdy_empty[%0d]", idx), {31'h0, rr_v[idx]}, 32'h1);
    rm_v[idx] = w;
    rv_v[idx] = 1'b1;
    wclk(1);
    rv_v[idx] = 1'b0;
    check($sformatf("recv_rdy_full[%0d]", idx), {31'h0, rr_v[idx]}, 32'h0);
  endtask

  task automatic drain(input int idx);
    check($sformatf("send_val_pre[%0d]", idx), {31'h0, sv_v[idx]}, {31'h0, m_full[idx]});
    if (m_full[idx]) begin
      check($sformatf("send_msg[%0d]", idx), get_sm(idx), m_word[idx]);
      srdy_v[idx] = 1'b1;
      wclk(1);
      srdy_v[idx] = 1'b0;
      m_full[idx] = 1'b0;
    end
    wclk(1);
    check($sformatf("send_val_post[%0d]", idx), {31'h0, sv_v[idx]}, 32'h0);
  endtask

  task automatic frame(input int idx, input logic [31:0] tx, input int nsent,
                       input bit pre, input logic [31:0] pw);
    logic [31:0] rx, exp_rx;
    logic [63:0] mask;
    int          nb, uf0, ov0, fe0;
    bit          exp_ov, exp_fe;
    nb   = nb_of[idx];
    mask = (64'd1 << nb) - 64'd1;
    if (pre) preload(idx, pw);
    uf0 = uf_cnt[idx];
    ov0 = ov_cnt[idx];
    fe0 = fe_cnt[idx];
    xfer(idx, tx, nsent, 1'b0, rx);
    exp_rx = pre ? 32'((64'(pw) & mask) >> (nb - nsent)) : 32'h0;
    exp_ov = 1'b0;
    exp_fe = 1'b0;
    if (nsent == nb) begin
      if (m_full[idx]) exp_ov = 1'b1;
      else begin
        m_full[idx] = 1'b1;
        m_word[idx] = 32'(64'(tx) & mask);
      end
    end else begin
      exp_fe = 1'b1;
    end
    check($sformatf("miso_word[%0d]", idx), rx, exp_rx);
    check($sformatf("underflow[%0d]", idx), 32'(uf_cnt[idx] - uf0), pre ? 32'h0 : 32'h1);
    check($sformatf("overflow[%0d]", idx), 32'(ov_cnt[idx] - ov0), {31'h0, exp_ov});
    check($sformatf("frame_err[%0d]", idx), 32'(fe_cnt[idx] - fe0), {31'h0, exp_fe});
    check($sformatf("send_val[%0d]", idx), {31'h0, sv_v[idx]}, {31'h0, m_full[idx]});
    if (m_full[idx]) check($sformatf("send_msg_hold[%0d]", idx), get_sm(idx), m_word[idx]);
  endtask

  task automatic check_reset_outputs(input int idx);
    check($sformatf("rst_miso[%0d]", idx), {31'h0, miso_v[idx]}, 32'h0);
    check($sformatf("rst_recv_rdy[%0d]", idx), {31'h0, rr_v[idx]}, 32'h1);
    check($sformatf("rst_send_val[%0d]", idx), {31'h0, sv_v[idx]}, 32'h0);
    check($sformatf("rst_busy[%0d]", idx), {31'h0, busy_v[idx]}, 32'h0);
    check($sformatf("rst_pulses[%0d]", idx), {29'h0, uf_v[idx], ov_v[idx], fe_v[idx]}, 32'h0);
  endtask

  initial begin
    #10000000;
    $display("FAIL watchdog: simulation did not finish, got timeout expected completion");
    $fatal(1);
  end

  initial begin
    logic [31:0] rx;
    int          uf0, ov0, fe0, idx, nsent;
    bit          pre;

    for (int i = 0; i < 4; i++) begin
      sclk_v[i] = (cpol_of[i] != 0);
      cs_v[i]   = 1'b1;
      mosi_v[i] = 1'b0;
      rm_v[i]   = 32'h0;
      rv_v[i]   = 1'b0;
      srdy_v[i] = 1'b0;
      m_full[i] = 1'b0;
      m_word[i] = 32'h0;
    end
    reset = 1'b0;
    wclk(3);
    for (int i = 0; i < 4; i++) check_reset_outputs(i);
`ifdef SPI_MINION_STREAM_ERR_CNT_EN
    check("err_cnt_reset", {8'h0, ec_v[0]}, 32'h0);
`endif
    reset = 1'b1;
    wclk(5);

    // Basic 32-bit exchange and the three other SPI modes.
    frame(0, 32'h12345678, 32, 1'b1, 32'hA5A5F00F);
    drain(0);
    for (int m = 1; m < 4; m++) begin
      frame(m, 32'hC3, 8, 1'b1, 32'h3C);
      drain(m);
    end

    // Underflow: nothing preloaded.
    frame(0, 32'h0BADF00D, 32, 1'b0, 32'h0);
    drain(0);

    // Overflow: two frames with the device stalled.
    frame(0, 32'h11111111, 32, 1'b1, $urandom);
    frame(0, 32'h22222222, 32, 1'b1, $urandom);
    drain(0);

    // Short frame then a good one.
    frame(0, $urandom, 31, 1'b1, $urandom);
    frame(0, 32'hDEADBEEF, 32, 1'b1, $urandom);
    drain(0);

    // Reset mid-frame with a full RX buffer and a preloaded TX word.
    frame(0, 32'h55AA55AA, 32, 1'b1, $urandom);
    preload(0, 32'h77777777);
    uf0 = uf_cnt[0];
    ov0 = ov_cnt[0];
    fe0 = fe_cnt[0];
    xfer(0, 32'hFFFFFFFF, 10, 1'b1, rx);
    reset = 1'b0;
    wclk(2);
    check_reset_outputs(0);
    reset = 1'b1;
    for (int i = 0; i < 4; i++) m_full[i] = 1'b0;
    wclk(20);
    check("busy_after_release", {31'h0, busy_v[0]}, 32'h0);
    check("pulses_across_reset", 32'((uf_cnt[0] - uf0) + (ov_cnt[0] - ov0) + (fe_cnt[0] - fe0)), 32'h0);
    cs_v[0]   = 1'b1;
    sclk_v[0] = 1'b0;
    wclk(2 * HALF);
    frame(0, 32'h0F0F0F0F, 32, 1'b0, 32'h0);
    drain(0);

    // Randomised frames across all instances.
    for (int it = 0; it < 24; it++) begin
      idx = $urandom_range(0, 3);
      if (m_full[idx] && ($urandom % 2 == 0)) drain(idx);
      pre   = ($urandom % 2 == 0);
      nsent = ($urandom % 4 == 0) ? $urandom_range(1, nb_of[idx] - 1) : nb_of[idx];
      frame(idx, $urandom, nsent, pre, $urandom);
    end
    for (int i = 0; i < 4; i++) drain(i);

`ifdef SPI_MINION_STREAM_ERR_CNT_EN
    reset = 1'b0;
    wclk(2);
    reset = 1'b1;
    for (int i = 0; i < 4; i++) m_full[i] = 1'b0;
    wclk(5);
    frame(0, $urandom, 32, 1'b0, 32'h0);
    drain(0);
    for (int k = 0; k < 300; k++) frame(0, $urandom, 1, 1'b1, $urandom);
    check("err_cnt", {8'h0, ec_v[0]}, 32'h00FF0001);
`endif

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule

`default_nettype wire
